// File: rtl/capture_ctrl.sv
// Capture sequencer: decimates samples, fills the pre-trigger window, arms, then counts post-trigger writes.
// Optional force_trig input enabled by defining CAPTURE_CTRL_FORCE_TRIG_EN.
module capture_ctrl #(
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic            capture_done,
    input  logic [3:0]      decimator,
    input  logic [LOG2-1:0] trig_pos,
    input  logic            smpl_vld,
    input  logic            triggered,
`ifdef CAPTURE_CTRL_FORCE_TRIG_EN
    input  logic            force_trig,
`endif
    output logic [LOG2-1:0] ram_addr,
    output logic            we,
    output logic            armed,
    output logic            capturing,
    output logic            set_capture_done
);

    typedef enum logic [2:0] {IDLE, CAPTURE, ARMED, POST, DONE} state_t;

    localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);
    localparam logic [LOG2:0]   FULL = (LOG2 + 1)'(ENTRIES);

    state_t          state, state_next;
    logic [14:0]     dec_cnt;
    logic [14:0]     dec_max;
    logic [LOG2:0]   pre_cnt;
    logic [LOG2:0]   threshold;
    logic [LOG2-1:0] post_cnt;
    logic [LOG2-1:0] trig_pos_c;
    logic            writing;
    logic            accept;
    logic            fire;
    logic            done_now;
    logic            final_accept;
    logic            final_wr;

    always_comb begin
        trig_pos_c = (trig_pos > LAST) ? LAST : trig_pos;
        threshold  = FULL - {1'b0, trig_pos_c};
        dec_max    = 15'((16'd1 << decimator) - 16'd1);
        writing    = run && (state == CAPTURE || state == ARMED || state == POST);
        accept     = writing && smpl_vld && (dec_cnt == dec_max);
`ifdef CAPTURE_CTRL_FORCE_TRIG_EN
        fire = (state == ARMED && triggered) ||
               (force_trig && (state == CAPTURE || state == ARMED));
`else
        fire = (state == ARMED) && triggered;
`endif
    end

    always_comb begin
        state_next   = state;
        done_now     = 1'b0;
        final_accept = 1'b0;
        armed        = (state == ARMED);
        capturing    = (state == CAPTURE || state == ARMED || state == POST);
        case (state)
            IDLE: begin
                if (run && !capture_done)
                    state_next = CAPTURE;
            end
            CAPTURE, ARMED: begin
                if (!run) begin
                    state_next = IDLE;
                end else if (fire) begin
                    // A zero-length post window completes on the trigger itself
                    if (trig_pos_c == '0) begin
                        state_next = DONE;
                        done_now   = 1'b1;
                    end else begin
                        state_next = POST;
                    end
                end else if (state == CAPTURE && pre_cnt == threshold) begin
                    state_next = ARMED;
                end
            end
            POST: begin
                if (!run) begin
                    state_next = IDLE;
                end else if (accept && (post_cnt + LOG2'(1) == trig_pos_c)) begin
                    state_next   = DONE;
                    final_accept = 1'b1;
                end
            end
            DONE: begin
                if (!run)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            ram_addr         <= LAST;
            we               <= 1'b0;
            set_capture_done <= 1'b0;
            final_wr         <= 1'b0;
            dec_cnt          <= '0;
            pre_cnt          <= '0;
            post_cnt         <= '0;
        end else begin
            state            <= state_next;
            we               <= accept;
            final_wr         <= final_accept;
            // The pulse lands one cycle after the final write's enable
            set_capture_done <= final_wr | done_now;
            if (state == IDLE && state_next == CAPTURE) begin
                ram_addr <= LAST;
                dec_cnt  <= '0;
                pre_cnt  <= '0;
                post_cnt <= '0;
            end else begin
                if (writing && smpl_vld)
                    dec_cnt <= accept ? 15'd0 : dec_cnt + 15'd1;
                if (accept) begin
                    ram_addr <= (ram_addr == LAST) ? '0 : ram_addr + LOG2'(1);
                    if (state == POST)
                        post_cnt <= post_cnt + LOG2'(1);
                    else if (pre_cnt != FULL)
                        pre_cnt <= pre_cnt + (LOG2 + 1)'(1);
                end
                if (state != POST && state_next == POST)
                    post_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed self-checking bench for capture_ctrl; inputs change and outputs are sampled at the falling edge.
// The force-trigger scenario runs only when CAPTURE_CTRL_FORCE_TRIG_EN is defined.
module tb_capture_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       capture_done = 1'b0;
    logic [3:0] decimator = 4'd0;
    logic [8:0] trig_pos = 9'd0;
    logic       smpl_vld = 1'b0;
    logic       triggered = 1'b0;
`ifdef CAPTURE_CTRL_FORCE_TRIG_EN
    logic       force_trig = 1'b0;
`endif
    logic [8:0] ram_addr;
    logic       we;
    logic       armed;
    logic       capturing;
    logic       set_capture_done;

    int checks = 0;
    int failures = 0;
    int we_cnt = 0;
    int done_cnt = 0;
    logic [8:0] last_addr = '0;

    capture_ctrl #(.ENTRIES(384), .LOG2(9)) dut (
        .clk(clk), .rst(rst), .run(run), .capture_done(capture_done),
        .decimator(decimator), .trig_pos(trig_pos), .smpl_vld(smpl_vld),
        .triggered(triggered),
`ifdef CAPTURE_CTRL_FORCE_TRIG_EN
        .force_trig(force_trig),
`endif
        .ram_addr(ram_addr), .we(we), .armed(armed), .capturing(capturing),
        .set_capture_done(set_capture_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        if (we) begin
            we_cnt++;
            last_addr = ram_addr;
        end
        if (set_capture_done) done_cnt++;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        // Reset state
        tick(); tick();
        checkOutput("rst_addr", 32'(ram_addr), 383);
        checkOutput("rst_we", 32'(we), 0);
        checkOutput("rst_armed", 32'(armed), 0);
        checkOutput("rst_capturing", 32'(capturing), 0);
        checkOutput("rst_done", 32'(set_capture_done), 0);
        rst = 1'b0;
        tick();

        $display("[TB] scenario 1: full capture with trigger after write 300");
        trig_pos = 9'd128; run = 1'b1; smpl_vld = 1'b1;
        tick();
        for (int i = 0; i < 400 && !(we && ram_addr == 9'd255); i++) tick();
        checkOutput("s1_addr255", 32'(ram_addr), 255);
        checkOutput("s1_not_armed_yet", 32'(armed), 0);
        tick();
        checkOutput("s1_armed", 32'(armed), 1);
        for (int i = 0; i < 100 && !(we && ram_addr == 9'd298); i++) tick();
        checkOutput("s1_addr298", 32'(ram_addr), 298);
        triggered = 1'b1;
        tick();
        triggered = 1'b0;
        checkOutput("s1_write300_addr", 32'(ram_addr), 299);
        checkOutput("s1_post_state", 32'({armed, capturing}), 1);
        we_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 300 && !set_capture_done; i++) tick();
        checkOutput("s1_post_writes", 32'(we_cnt), 128);
        checkOutput("s1_final_addr", 32'(last_addr), 43);
        checkOutput("s1_pulse_no_we", 32'(we), 0);
        repeat (4) tick();
        checkOutput("s1_pulse_once", 32'(done_cnt), 1);
        checkOutput("s1_no_more_we", 32'(we_cnt), 128);
        checkOutput("s1_hold_addr", 32'(ram_addr), 43);

        $display("[TB] scenario 2: decimation by 4");
        run = 1'b0; smpl_vld = 1'b0; decimator = 4'd2;
        tick();
        run = 1'b1;
        tick();
        we_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            smpl_vld = 1'b1;
            tick();
            checkOutput("s2_we_after_strobe", 32'(we), (k % 4 == 3) ? 1 : 0);
            if (k % 4 == 3) checkOutput("s2_addr", 32'(ram_addr), 32'(k / 4));
            smpl_vld = 1'b0;
            tick();
        end
        checkOutput("s2_we_count", 32'(we_cnt), 4);

        $display("[TB] scenario 3: trigger held high from start");
        run = 1'b0; decimator = 4'd0;
        tick();
        run = 1'b1; triggered = 1'b1; smpl_vld = 1'b1;
        tick();
        we_cnt = 0;
        for (int i = 0; i < 400 && !armed; i++) tick();
        checkOutput("s3_armed", 32'(armed), 1);
        checkOutput("s3_writes_at_arm", 32'(we_cnt), 257);
        tick();
        checkOutput("s3_armed_one_cycle", 32'(armed), 0);
        checkOutput("s3_capturing", 32'(capturing), 1);
        we_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 300 && !set_capture_done; i++) tick();
        checkOutput("s3_post_writes", 32'(we_cnt), 128);
        checkOutput("s3_final_addr", 32'(last_addr), 1);
        checkOutput("s3_pulse", 32'(done_cnt), 1);

        $display("[TB] scenario 4: abort during post-trigger");
        run = 1'b0; triggered = 1'b0;
        tick();
        run = 1'b1;
        tick();
        for (int i = 0; i < 400 && !armed; i++) tick();
        checkOutput("s4_armed", 32'(armed), 1);
        triggered = 1'b1;
        tick();
        triggered = 1'b0;
        we_cnt = 0; done_cnt = 0;
        repeat (10) tick();
        checkOutput("s4_post_writes", 32'(we_cnt), 10);
        run = 1'b0;
        tick();
        checkOutput("s4_capturing_off", 32'(capturing), 0);
        checkOutput("s4_we_off", 32'(we), 0);
        tick(); tick();
        checkOutput("s4_no_done_pulse", 32'(done_cnt), 0);
        run = 1'b1;
        tick();
        checkOutput("s4_rerun_addr", 32'(ram_addr), 383);
        checkOutput("s4_rerun_capturing", 32'(capturing), 1);
        tick();
        checkOutput("s4_first_write", 32'({we, ram_addr}), 32'({1'b1, 9'd0}));

        $display("[TB] scenario 5: zero post-trigger length");
        run = 1'b0; smpl_vld = 1'b0; trig_pos = 9'd0;
        tick();
        run = 1'b1;
        tick();
        smpl_vld = 1'b1; we_cnt = 0;
        repeat (384) tick();
        checkOutput("s5_writes", 32'(we_cnt), 384);
        checkOutput("s5_last_addr", 32'(ram_addr), 383);
        checkOutput("s5_not_armed_yet", 32'(armed), 0);
        smpl_vld = 1'b0;
        tick();
        checkOutput("s5_armed", 32'(armed), 1);
        triggered = 1'b1; done_cnt = 0;
        tick();
        triggered = 1'b0;
        checkOutput("s5_pulse", 32'(set_capture_done), 1);
        checkOutput("s5_capturing_off", 32'(capturing), 0);
        tick();
        checkOutput("s5_pulse_single", 32'(set_capture_done), 0);
        checkOutput("s5_no_more_we", 32'(we_cnt), 384);
        capture_done = 1'b1; run = 1'b0;
        tick();
        run = 1'b1;
        tick(); tick();
        checkOutput("s5_blocked", 32'(capturing), 0);
        capture_done = 1'b0;
        tick();
        checkOutput("s5_restart", 32'(capturing), 1);

        $display("[TB] scenario: trig_pos clamp");
        run = 1'b0;
        tick();
        trig_pos = 9'd500; run = 1'b1;
        tick();
        smpl_vld = 1'b1;
        tick();
        smpl_vld = 1'b0;
        tick();
        checkOutput("clamp_armed", 32'(armed), 1);

`ifdef CAPTURE_CTRL_FORCE_TRIG_EN
        $display("[TB] scenario 6: forced trigger");
        run = 1'b0;
        tick();
        trig_pos = 9'd64; run = 1'b1;
        tick();
        smpl_vld = 1'b1;
        repeat (19) tick();
        checkOutput("s6_addr18", 32'(ram_addr), 18);
        force_trig = 1'b1;
        tick();
        force_trig = 1'b0;
        checkOutput("s6_addr19", 32'(ram_addr), 19);
        we_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 200 && !set_capture_done; i++) tick();
        checkOutput("s6_post_writes", 32'(we_cnt), 64);
        checkOutput("s6_final_addr", 32'(last_addr), 83);
        repeat (3) tick();
        checkOutput("s6_pulse_once", 32'(done_cnt), 1);
        smpl_vld = 1'b0;
`endif

        $display("[TB] scenario: reset mid-capture");
        run = 1'b0;
        tick();
        trig_pos = 9'd128; run = 1'b1;
        tick();
        smpl_vld = 1'b1;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        checkOutput("midrst_addr", 32'(ram_addr), 383);
        checkOutput("midrst_capturing", 32'(capturing), 0);
        checkOutput("midrst_we", 32'(we), 0);
        rst = 1'b0; run = 1'b0; smpl_vld = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
